morse_pulse_generator: RTL and testbench

//  Transmit-side counterpart of the key-input pulse decoder. Accepts pulse-event codes
//  (dit/dash/letter space/word space) through a valid/ready handshake into a small FIFO.

---
 rtl/morse_pulse_generator_if.sv | 27 ++
 rtl/morse_pulse_generator.sv | 233 +++++++++++++++++++++++
 tb/tb_morse_pulse_generator.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/morse_pulse_generator_if.sv
//------------------------------------------------------------------------------
// Module      : morse_pulse_generator_if
// Description : Valid/ready event handshake between a pulse-code source and
//               the morse pulse generator.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface morse_pulse_generator_if;
    logic [2:0] event_in;
    logic       event_valid;
    logic       event_ready;

    modport master (
        output event_in,
        output event_valid,
        input  event_ready
    );

    modport slave (
        input  event_in,
        input  event_valid,
        output event_ready
    );
endinterface

`default_nettype wire

// File: rtl/morse_pulse_generator.sv
//------------------------------------------------------------------------------
// Module      : morse_pulse_generator
// Description : Queues dit/dash/space codes in a FIFO and replays them as a
//               timed keying waveform. Optional sidetone via SIDETONE_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module morse_pulse_generator #(
    parameter int DIT_TIME          = 100,
    parameter int DASH_TIME         = 300,
    parameter int ELEMENT_GAP_TIME  = 100,
    parameter int LETTER_SPACE_TIME = 200,
    parameter int WORD_SPACE_TIME   = 600,
    parameter int TIMER_WIDTH       = 12,
    parameter int FIFO_DEPTH        = 8
`ifdef SIDETONE_EN
    ,
    parameter int TONE_HALF_PERIOD  = 1
`endif
) (
    input  logic                          clock_1khz,
    input  logic                          rst_n,
    morse_pulse_generator_if.slave        evt,
    input  logic                          enable,
    input  logic                          flush,
    output logic                          morse_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef SIDETONE_EN
    ,
    output logic                          tone_out
`endif
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

    localparam logic [2:0] c_CODE_DIT    = 3'd1;
    localparam logic [2:0] c_CODE_DASH   = 3'd2;
    localparam logic [2:0] c_CODE_LETTER = 3'd3;
    localparam logic [2:0] c_CODE_WORD   = 3'd4;

    // Timer holds N-1 on entry and counts to zero, so a state lasts N cycles.
    localparam logic [TIMER_WIDTH-1:0] c_DIT_LOAD    = TIMER_WIDTH'(DIT_TIME - 1);
    localparam logic [TIMER_WIDTH-1:0] c_DASH_LOAD   = TIMER_WIDTH'(DASH_TIME - 1);
    localparam logic [TIMER_WIDTH-1:0] c_GAP_LOAD    = TIMER_WIDTH'(ELEMENT_GAP_TIME - 1);
    localparam logic [TIMER_WIDTH-1:0] c_LETTER_LOAD = TIMER_WIDTH'(LETTER_SPACE_TIME - 1);
    localparam logic [TIMER_WIDTH-1:0] c_WORD_LOAD   = TIMER_WIDTH'(WORD_SPACE_TIME - 1);
    localparam logic [TIMER_WIDTH-1:0] c_TIMER_ONE   = TIMER_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MARK  = 2'd1,
        S_GAP   = 2'd2,
        S_SPACE = 2'd3
    } state_t;

    // FIFO storage and bookkeeping
    logic [2:0]          r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;

    // Keying FSM
    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [TIMER_WIDTH-1:0]  r_timer;
    logic [TIMER_WIDTH-1:0]  w_timer_nxt;
    logic                    r_morse;
    logic                    w_morse_nxt;

    logic        w_code_ok;
    logic        w_push;
    logic        w_pop;
    logic        w_fifo_empty;
    logic        w_timer_done;
    logic [2:0]  w_head;

    assign evt.event_ready = (r_count != c_CNT_FULL);

    // Codes outside 1..4 complete the handshake but are never stored.
    assign w_code_ok    = (evt.event_in >= c_CODE_DIT) && (evt.event_in <= c_CODE_WORD);
    assign w_push       = evt.event_valid & evt.event_ready & w_code_ok & ~flush;
    assign w_fifo_empty = (r_count == '0);
    assign w_head       = r_mem[r_rd_ptr];
    assign w_timer_done = (r_timer == '0);

    always_ff @(posedge clock_1khz) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= evt.event_in;
        end
    end

    always_ff @(posedge clock_1khz or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock_1khz or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_morse <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_morse <= w_morse_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_morse_nxt = r_morse;
        w_pop       = 1'b0;

        if (flush) begin
            w_state_nxt = S_IDLE;
            w_timer_nxt = '0;
            w_morse_nxt = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable && !w_fifo_empty) begin
                        w_pop = 1'b1;
                        case (w_head)
                            c_CODE_DIT: begin
                                w_state_nxt = S_MARK;
                                w_timer_nxt = c_DIT_LOAD;
                                w_morse_nxt = 1'b1;
                            end
                            c_CODE_DASH: begin
                                w_state_nxt = S_MARK;
                                w_timer_nxt = c_DASH_LOAD;
                                w_morse_nxt = 1'b1;
                            end
                            c_CODE_LETTER: begin
                                w_state_nxt = S_SPACE;
                                w_timer_nxt = c_LETTER_LOAD;
                            end
                            default: begin
                                w_state_nxt = S_SPACE;
                                w_timer_nxt = c_WORD_LOAD;
                            end
                        endcase
                    end
                end

                S_MARK: begin
                    if (w_timer_done) begin
                        w_state_nxt = S_GAP;
                        w_timer_nxt = c_GAP_LOAD;
                        w_morse_nxt = 1'b0;
                    end else begin
                        w_timer_nxt = r_timer - c_TIMER_ONE;
                    end
                end

                S_GAP, S_SPACE: begin
                    if (w_timer_done) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_timer_nxt = r_timer - c_TIMER_ONE;
                    end
                end

                default: begin
                    w_state_nxt = S_IDLE;
                    w_timer_nxt = '0;
                    w_morse_nxt = 1'b0;
                end
            endcase
        end
    end

    assign morse_out  = r_morse;
    assign busy       = (r_state != S_IDLE) | ~w_fifo_empty;
    assign fifo_count = r_count;

`ifdef SIDETONE_EN
    localparam int c_TONE_W = (TONE_HALF_PERIOD > 1) ? $clog2(TONE_HALF_PERIOD) : 1;
    localparam logic [c_TONE_W-1:0] c_TONE_LAST = c_TONE_W'(TONE_HALF_PERIOD - 1);
    localparam logic [c_TONE_W-1:0] c_TONE_ONE  = c_TONE_W'(1);

    logic [c_TONE_W-1:0] r_tone_div;
    logic                r_tone;

    // Divider restarts from zero on every mark so each element starts in phase.
    always_ff @(posedge clock_1khz or negedge rst_n) begin
        if (!rst_n) begin
            r_tone_div <= '0;
            r_tone     <= 1'b0;
        end else if (!r_morse) begin
            r_tone_div <= '0;
            r_tone     <= 1'b0;
        end else if (r_tone_div == c_TONE_LAST) begin
            r_tone_div <= '0;
            r_tone     <= ~r_tone;
        end else begin
            r_tone_div <= r_tone_div + c_TONE_ONE;
        end
    end

    assign tone_out = r_tone;
`endif

endmodule

`default_nettype wire

// File: tb/tb_morse_pulse_generator.sv
//------------------------------------------------------------------------------
// Module      : tb_morse_pulse_generator
// Description : Scoreboard bench for morse_pulse_generator with randomized
//               event bursts and directed corner cases.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_morse_pulse_generator;

    localparam int DIT   = 100;
    localparam int DASH  = 300;
    localparam int GAP   = 100;
    localparam int LS    = 200;
    localparam int WS    = 600;
    localparam int DEPTH = 8;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       enable  = 1'b0;
    logic       flush   = 1'b0;
    logic       morse_out;
    logic       busy;
    logic [3:0] fifo_count;
`ifdef SIDETONE_EN
    logic       tone_out;
`endif

    morse_pulse_generator_if evt();

    morse_pulse_generator dut (
        .clock_1khz (clk),
        .rst_n      (rst_n),
        .evt        (evt),
        .enable     (enable),
        .flush      (flush),
        .morse_out  (morse_out),
        .busy       (busy),
        .fifo_count (fifo_count)
`ifdef SIDETONE_EN
        ,
        .tone_out   (tone_out)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int low_before;
        int mark_len;
    } exp_t;

    exp_t sb[$];
    int   exp_trailing = -1;
    bit   mon_en       = 1'b0;

    // Reference model state for the burst being issued
    bit   m_first;
    int   m_pend;
    int   m_count;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic begin_burst();
        m_first = 1'b1;
        m_pend  = 0;
        m_count = 0;
    endtask

    task automatic end_burst();
        exp_trailing = m_first ? -1 : GAP + m_pend;
    endtask

    // A mark is preceded by the previous gap, one idle cycle, and every
    // queued space (each also followed by one idle cycle).
    task automatic model_accept(input logic [2:0] code);
        exp_t e;
        case (code)
            3'd1, 3'd2: begin
                e.low_before = m_first ? -1 : GAP + 1 + m_pend;
                e.mark_len   = (code == 3'd1) ? DIT : DASH;
                sb.push_back(e);
                m_first = 1'b0;
                m_pend  = 0;
                m_count++;
            end
            3'd3: begin m_pend += LS + 1; m_count++; end
            3'd4: begin m_pend += WS + 1; m_count++; end
            default: ;
        endcase
    endtask

    task automatic push(input logic [2:0] code, input bit exp_ready);
        evt.event_in    = code;
        evt.event_valid = 1'b1;
        check("event_ready", evt.event_ready, exp_ready);
        if (exp_ready) model_accept(code);
        @(posedge clk); #1;
        evt.event_valid = 1'b0;
        evt.event_in    = 3'd0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: busy=1 after %0d cycles, expected 0", name, n);
        end
        @(negedge clk); #1;
        check({name, "_sb_empty"}, sb.size(), 0);
        check({name, "_tail_seen"}, exp_trailing, -1);
    endtask

    task automatic wait_mark(input string name);
        int n = 0;
        while (!morse_out && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!morse_out) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: morse_out=0 after %0d cycles, expected 1", name, n);
        end
    endtask

    // Monitor: measures mark lengths, low intervals and busy tail
    bit   m_prev;
    bit   b_prev;
    int   hi_cnt;
    int   lo_cnt;
    int   cur_mark;
    exp_t mon_e;

    always @(negedge clk) begin
        if (!mon_en) begin
            m_prev   = 1'b0;
            b_prev   = busy;
            hi_cnt   = 0;
            lo_cnt   = 0;
            cur_mark = -1;
        end else begin
            if (morse_out && !m_prev) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_mark: got a rising edge, expected none queued");
                    cur_mark = -1;
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.low_before >= 0)
                        check("low_between_marks", lo_cnt, mon_e.low_before);
                    cur_mark = mon_e.mark_len;
                end
                hi_cnt = 1;
            end else if (morse_out) begin
                hi_cnt++;
            end else if (m_prev) begin
                if (cur_mark >= 0) check("mark_length", hi_cnt, cur_mark);
                lo_cnt = 1;
            end else begin
                if (b_prev && !busy && exp_trailing >= 0) begin
                    check("busy_tail", lo_cnt, exp_trailing);
                    exp_trailing = -1;
                end
                lo_cnt++;
            end
            m_prev = morse_out;
            b_prev = busy;
        end
    end

    initial begin
        evt.event_in    = 3'd0;
        evt.event_valid = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_morse_out", morse_out, 0);
        check("rst_busy", busy, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_event_ready", evt.event_ready, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        // Single dit from idle
        enable = 1'b1;
        begin_burst();
        push(3'd1, 1'b1);
        end_burst();
        wait_idle("single_dit");

        // dash, dit, letter space, dit
        begin_burst();
        push(3'd2, 1'b1);
        push(3'd1, 1'b1);
        push(3'd3, 1'b1);
        push(3'd1, 1'b1);
        end_burst();
        wait_idle("sequence");

        // Fill FIFO with enable low; ninth push must be refused
        enable = 1'b0;
        begin_burst();
        for (int i = 0; i < DEPTH; i++) push(3'd1, 1'b1);
        check("full_count", fifo_count, DEPTH);
        push(3'd1, 1'b0);
        check("full_count_after_refused", fifo_count, DEPTH);
        check("full_busy", busy, 1);
        end_burst();
        enable = 1'b1;
        wait_idle("full_drain");

        // Codes 6 and 0 accepted but not stored
        begin_burst();
        push(3'd6, 1'b1);
        push(3'd0, 1'b1);
        check("invalid_count", fifo_count, 0);
        check("invalid_busy", busy, 0);
        end_burst();
        repeat (3) @(posedge clk);
        #1;
        check("invalid_morse_out", morse_out, 0);

        // Randomized bursts
        for (int b = 0; b < 8; b++) begin
            int n;
            bit en;
            n  = $urandom_range(1, 5);
            en = 1'($urandom_range(0, 1));
            enable = en;
            begin_burst();
            for (int i = 0; i < n; i++) push(3'($urandom_range(0, 7)), 1'b1);
            if (!en) check("burst_count", fifo_count, m_count);
            end_burst();
            enable = 1'b1;
            wait_idle("random_burst");
        end

        // Flush at mark cycle 150 of a dash with three queued
        mon_en = 1'b0;
        enable = 1'b1;
        push(3'd2, 1'b1);
        push(3'd1, 1'b1);
        push(3'd1, 1'b1);
        push(3'd1, 1'b1);
        sb.delete();
        exp_trailing = -1;
        wait_mark("flush");
        repeat (149) @(posedge clk);
        #1;
        check("flush_pre_morse", morse_out, 1);
        check("flush_pre_count", fifo_count, 3);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_morse_out", morse_out, 0);
        check("flush_count", fifo_count, 0);
        check("flush_busy", busy, 0);
        repeat (5) @(posedge clk);
        #1;
        check("flush_stays_low", morse_out, 0);

        // Asynchronous reset mid-mark
        push(3'd1, 1'b1);
        sb.delete();
        wait_mark("reset");
        repeat (20) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_morse_out", morse_out, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_count", fifo_count, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

`ifdef SIDETONE_EN
        begin
            int  rises;
            bit  t_prev;
            rises  = 0;
            t_prev = 1'b0;
            push(3'd1, 1'b1);
            sb.delete();
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                if (morse_out && tone_out && !t_prev) rises++;
                t_prev = tone_out;
            end
            check("tone_periods", rises, DIT / 2);
            check("tone_idle_low", tone_out, 0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
